// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer: run-control
// states, default widths and the absolute jump-target table.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PC_W_DEF    = 10;
    localparam int LUT_W_DEF   = 5;
    localparam int JMP_ENTRIES = 2 ** LUT_W_DEF;

    typedef logic [JMP_ENTRIES-1:0][PC_W_DEF-1:0] jmp_lut_t;

    // Entry i targets i*16; entry 3 is pulled in to 40 so a jump lands
    // on an address that is not a 16-word boundary.
    function automatic jmp_lut_t build_jmp_lut();
        jmp_lut_t lut;
        for (int i = 0; i < JMP_ENTRIES; i++) begin
            lut[i] = (i == 3) ? PC_W_DEF'(40) : PC_W_DEF'(i * 16);
        end
        return lut;
    endfunction

    localparam jmp_lut_t JMP_LUT = build_jmp_lut();

endpackage

// File: rtl/jump_lut.sv
// Read-only combinational ROM mapping a decoder jump index to an absolute
// program address. Targets wider than PC_W are truncated.
module jump_lut
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic [LUT_W-1:0] idx,
    output logic [PC_W-1:0]  target
);

    // Table lookup; every index value has an entry.
    always_comb begin
        target = PC_W'(JMP_LUT[idx]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / next-PC stage: Start/Done run control, stall, halt,
// absolute jumps through a LUT, sticky overrun and a saturating cycle counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_W      = LUT_W_DEF,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Jen,
    input  logic [LUT_W-1:0] JmpIdx,
    input  logic             Halt,
    output logic [PC_W-1:0]  Prog_ctr,
    output logic             Busy,
    output logic             Done,
    output logic             Overrun,
    output logic [CNT_W-1:0] CycleCnt
);

    localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]  PC_LAST  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nx;
    logic [PC_W-1:0]  pc, pc_nx, target;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ovr, ovr_nx;
    logic             busy_q, done_q;

    jump_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_jump_lut (
        .idx    (JmpIdx),
        .target (target)
    );

    // State, PC, counter and registered Busy/Done decodes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            pc     <= PC_START;
            cnt    <= '0;
            ovr    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, whatever the statement order.
            state  <= state_nx;
            pc     <= pc_nx;
            cnt    <= cnt_nx;
            ovr    <= ovr_nx;
            busy_q <= (state_nx == RUN);
            done_q <= (state_nx == DONE);
        end
    end

    // Next-state / next-PC: Start overrides everything; otherwise only an
    // unstalled RUN cycle advances, with Halt > taken jump > overrun > PC+1.
    always_comb begin
        // NOTE: hold values assigned first so no path leaves a signal unassigned (no latches).
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        ovr_nx   = ovr;

        if (Start) begin
            state_nx = RUN;
            pc_nx    = PC_START;
            cnt_nx   = '0;
            ovr_nx   = 1'b0;
        end else if (state == RUN && !Stall) begin
            if (cnt != CNT_MAX) begin
                cnt_nx = cnt + 1'b1;
            end
            if (Halt) begin
                state_nx = DONE;
            end else if (Branch && Jen) begin
                pc_nx = target;
            end else if (pc == PC_LAST) begin
                ovr_nx   = 1'b1;
                state_nx = DONE;
            end else begin
                pc_nx = pc + 1'b1;
            end
        end
    end

    assign Prog_ctr = pc;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Overrun  = ovr;
    assign CycleCnt = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-width instance for run control,
// jumps, stall, halt and async reset, plus a PC_W=4/CNT_W=3 instance for
// overrun and counter saturation.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;

    // Default-width instance.
    logic        start, stall, branch, jen, halt;
    logic [4:0]  jmp_idx;
    logic [9:0]  pc;
    logic        busy, done, ovr;
    logic [15:0] cnt;

    // Narrow instance.
    logic        s_start;
    logic [3:0]  s_pc;
    logic        s_busy, s_done, s_ovr;
    logic [2:0]  s_cnt;

    int passed = 0;
    int total  = 0;

    pc_sequencer dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Start    (start),
        .Stall    (stall),
        .Branch   (branch),
        .Jen      (jen),
        .JmpIdx   (jmp_idx),
        .Halt     (halt),
        .Prog_ctr (pc),
        .Busy     (busy),
        .Done     (done),
        .Overrun  (ovr),
        .CycleCnt (cnt)
    );

    pc_sequencer #(
        .PC_W  (4),
        .LUT_W (5),
        .CNT_W (3)
    ) dut_small (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Start    (s_start),
        .Stall    (1'b0),
        .Branch   (1'b0),
        .Jen      (1'b0),
        .JmpIdx   (5'd0),
        .Halt     (1'b0),
        .Prog_ctr (s_pc),
        .Busy     (s_busy),
        .Done     (s_done),
        .Overrun  (s_ovr),
        .CycleCnt (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        branch  = 1'b0;
        jen     = 1'b0;
        halt    = 1'b0;
        jmp_idx = 5'd0;
        s_start = 1'b0;

        // Reset state.
        step(2);
        check("rst_pc",   32'(pc),   0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovr",  32'(ovr),  0);
        check("rst_cnt",  32'(cnt),  0);
        check("rst_spc",  32'(s_pc), 0);

        rst_n = 1'b1;
        branch = 1'b1; jen = 1'b1; jmp_idx = 5'd3; halt = 1'b1;
        step(1);
        check("idle_pc",   32'(pc),   0);
        check("idle_busy", 32'(busy), 0);
        branch = 1'b0; jen = 1'b0; halt = 1'b0;

        // Start and 5 unstalled cycles.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_pc",   32'(pc),   0);
        check("start_busy", 32'(busy), 1);
        check("start_cnt",  32'(cnt),  0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("run_pc", 32'(pc), 32'(k));
        end
        check("run_cnt",  32'(cnt),  5);
        check("run_busy", 32'(busy), 1);

        // Taken jump at PC=7 through LUT[3]=40.
        step(2);
        check("pre_jmp_pc", 32'(pc), 7);
        branch = 1'b1; jen = 1'b1; jmp_idx = 5'd3;
        step(1);
        check("jmp_pc",  32'(pc),  40);
        check("jmp_cnt", 32'(cnt), 8);
        branch = 1'b0; jen = 1'b0;

        // Restart while running, then fall-through branch at PC=7.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_pc",   32'(pc),   0);
        check("restart_cnt",  32'(cnt),  0);
        check("restart_busy", 32'(busy), 1);
        step(7);
        branch = 1'b1; jen = 1'b0; jmp_idx = 5'd3;
        step(1);
        check("fall_pc", 32'(pc), 8);
        branch = 1'b0;

        // Stall at PC=12 with a pending taken jump.
        step(4);
        check("pre_stall_pc",  32'(pc),  12);
        check("pre_stall_cnt", 32'(cnt), 12);
        stall = 1'b1; branch = 1'b1; jen = 1'b1; jmp_idx = 5'd2;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("stall_pc",  32'(pc),  12);
            check("stall_cnt", 32'(cnt), 12);
        end
        stall = 1'b0;
        step(1);
        check("unstall_pc",  32'(pc),  32);
        check("unstall_cnt", 32'(cnt), 13);
        jmp_idx = 5'd1;
        step(1);
        check("jmp16_pc", 32'(pc), 16);
        branch = 1'b0; jen = 1'b0;

        // Halt wins over a taken jump at PC=20.
        step(4);
        check("pre_halt_pc", 32'(pc), 20);
        halt = 1'b1; branch = 1'b1; jen = 1'b1; jmp_idx = 5'd3;
        step(1);
        check("halt_pc",   32'(pc),   20);
        check("halt_done", 32'(done), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_cnt",  32'(cnt),  19);
        stall = 1'b1;
        step(2);
        check("done_pc",   32'(pc),   20);
        check("done_done", 32'(done), 1);
        check("done_cnt",  32'(cnt),  19);
        stall = 1'b0; halt = 1'b0; branch = 1'b0; jen = 1'b0;

        // Start out of DONE.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("rerun_pc",   32'(pc),   0);
        check("rerun_done", 32'(done), 0);
        check("rerun_busy", 32'(busy), 1);

        // Halt while stalled is ignored; takes effect once the stall drops.
        stall = 1'b1; halt = 1'b1;
        step(1);
        check("stall_halt_busy", 32'(busy), 1);
        check("stall_halt_cnt",  32'(cnt),  0);
        stall = 1'b0;
        step(1);
        check("halt0_done", 32'(done), 1);
        check("halt0_pc",   32'(pc),   0);
        check("halt0_cnt",  32'(cnt),  1);
        halt = 1'b0;

        // Async reset mid-run, observed without a clock edge.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        check("prerst_pc", 32'(pc), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_pc",   32'(pc),   0);
        check("async_busy", 32'(busy), 0);
        check("async_done", 32'(done), 0);
        check("async_cnt",  32'(cnt),  0);
        start = 1'b1;
        step(1);
        check("rst_start_busy", 32'(busy), 0);
        start = 1'b0;
        #1 rst_n = 1'b1;
        step(1);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_pc",   32'(pc),   0);

        // Narrow instance: overrun at PC=15 and counter saturation at 7.
        s_start = 1'b1;
        step(1);
        s_start = 1'b0;
        check("s_start_pc",  32'(s_pc),  0);
        check("s_start_cnt", 32'(s_cnt), 0);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            check("s_pc",  32'(s_pc),  32'(k));
            check("s_cnt", 32'(s_cnt), (k < 7) ? 32'(k) : 32'd7);
        end
        check("s_pre_ovr",  32'(s_ovr),  0);
        check("s_pre_busy", 32'(s_busy), 1);
        step(1);
        check("s_ovr",      32'(s_ovr),  1);
        check("s_ovr_done", 32'(s_done), 1);
        check("s_ovr_busy", 32'(s_busy), 0);
        check("s_ovr_pc",   32'(s_pc),   15);
        check("s_ovr_cnt",  32'(s_cnt),  7);
        step(1);
        check("s_hold_pc",  32'(s_pc),  15);
        check("s_hold_ovr", 32'(s_ovr), 1);
        s_start = 1'b1;
        step(1);
        s_start = 1'b0;
        check("s_clr_ovr",  32'(s_ovr),  0);
        check("s_clr_pc",   32'(s_pc),   0);
        check("s_clr_busy", 32'(s_busy), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
